// File: rtl/bgr_pkg.sv
// bgr_pkg: definitions shared by the bandgap reference controller.
// Holds the FSM state encoding, the register word offsets, the CTRL/STATUS bit
// positions, the register reset defaults and a byte-lane merge helper.
package bgr_pkg;

  // FSM states. The encoding is visible to software in STATUS[1:0].
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PORST  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } bgr_state_e;

  // Word offsets (adr[3:2]) inside the 16-byte register window.
  localparam logic [1:0] REG_CTRL       = 2'd0;
  localparam logic [1:0] REG_PORST_LEN  = 2'd1;
  localparam logic [1:0] REG_SETTLE_MAX = 2'd2;
  localparam logic [1:0] REG_STATUS     = 2'd3;

  // CTRL bits (write-only pulses).
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // STATUS bits.
  localparam int ST_READY_BIT  = 2;
  localparam int ST_FAULT_BIT  = 3;
  localparam int ST_IRQCLR_BIT = 4;

  // Reset defaults of the configuration registers.
  localparam logic [15:0] PORST_LEN_RST  = 16'd100;
  localparam logic [15:0] SETTLE_MAX_RST = 16'hFFFF;

  // Replace the bytes of old_v whose lane is enabled in sel with new_v.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bgr_ctrl_if.sv
// bgr_ctrl_if: Wishbone slave bus bundle of the bandgap controller.
// Signals keep their Wishbone names; the _i/_o suffixes are seen from the slave.
//   master modport : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  modport : the reverse
interface bgr_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/bgr_sync2.sv
// bgr_sync2: two-flop synchronizer for a single asynchronous level.
// Ports: clk_i clock, rst_n_i async active-low reset, d_i async input,
//        q_o synchronized output (two clock cycles of latency).
module bgr_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bgr_ctrl.sv
// bgr_ctrl: power-on / settle sequencer for a bandgap reference macro with a
// Wishbone register window (CTRL, PORST_LEN, SETTLE_MAX, STATUS).
// Ports:
//   wb_clk_i, wb_rst_n   clock, async active-low reset
//   wb                   Wishbone slave (bgr_ctrl_if.slave)
//   vbg_ok_i             async bandgap-in-range flag
//   porst_o              power-on reset to the macro, active-high
//   bgr_ready_o          reference settled (mirrors STATUS.ready)
//   irq_o                done interrupt
// Build option: define BGR_CTRL_IRQ_EN to enable irq_o; otherwise it is tied 0.
module bgr_ctrl
  import bgr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 16,
  parameter int          OK_FILT   = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  bgr_ctrl_if.slave  wb,
  input  logic       vbg_ok_i,
  output logic       porst_o,
  output logic       bgr_ready_o,
  output logic       irq_o
);

  localparam int                FILT_W   = $clog2(OK_FILT + 1);
  localparam logic [FILT_W-1:0] FILT_TGT = FILT_W'(OK_FILT);

  // Bus side
  logic             ack_q;
  logic [31:0]      dat_o_q;
  logic [CNT_W-1:0] porst_len_q;
  logic [CNT_W-1:0] settle_max_q;

  // Sequencer
  bgr_state_e        state_q;
  logic              porst_q;
  logic              ready_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cap_q;
  logic [FILT_W-1:0] filt_q;
  // Configuration copies latched at START, so mid-run writes wait for the next run.
  logic [CNT_W-1:0]  porst_len_act_q;
  logic [CNT_W-1:0]  settle_max_act_q;

  logic              ok_s;
  logic              acc_s;
  logic              hit_s;
  logic              wr_s;
  logic [1:0]        word_s;
  logic              start_s;
  logic              abort_s;
  logic              irq_clr_s;
  logic [31:0]       rdata_s;
  logic [CNT_W-1:0]  len_eff_s;
  logic [CNT_W-1:0]  smax_eff_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [FILT_W-1:0] filt_d;
  logic              ok_hit_s;
  logic              timeout_s;
  logic              done_entry_s;

  bgr_sync2 u_sync (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n),
    .d_i     (vbg_ok_i),
    .q_o     (ok_s)
  );

  // Bus decode; a new access is only taken while ack is low.
  assign acc_s     = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
  assign hit_s     = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_s      = acc_s & hit_s & wb.wbs_we_i;
  assign word_s    = wb.wbs_adr_i[3:2];
  assign start_s   = wr_s & (word_s == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_START_BIT];
  assign abort_s   = wr_s & (word_s == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_ABORT_BIT];
  assign irq_clr_s = wr_s & (word_s == REG_STATUS) & wb.wbs_sel_i[0] & wb.wbs_dat_i[ST_IRQCLR_BIT];

  // Read-data mux for the register window.
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      REG_CTRL:       rdata_s = 32'd0;
      REG_PORST_LEN:  rdata_s = 32'(porst_len_q);
      REG_SETTLE_MAX: rdata_s = 32'(settle_max_q);
      REG_STATUS: begin
        rdata_s[1:0]          = state_q;
        rdata_s[ST_READY_BIT] = ready_q;
        rdata_s[ST_FAULT_BIT] = fault_q;
        rdata_s[31:16]        = 16'(cap_q);
      end
      default:        rdata_s = 32'd0;
    endcase
  end

  // Wishbone ack/read-data and configuration register writes.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q        <= 1'b0;
      dat_o_q      <= 32'd0;
      porst_len_q  <= CNT_W'(PORST_LEN_RST);
      settle_max_q <= CNT_W'(SETTLE_MAX_RST);
    end else begin
      ack_q <= acc_s;
      if (acc_s) begin
        dat_o_q <= (hit_s && !wb.wbs_we_i) ? rdata_s : 32'd0;
      end
      if (wr_s && word_s == REG_PORST_LEN) begin
        porst_len_q <= CNT_W'(apply_sel(32'(porst_len_q), wb.wbs_dat_i, wb.wbs_sel_i));
      end
      if (wr_s && word_s == REG_SETTLE_MAX) begin
        settle_max_q <= CNT_W'(apply_sel(32'(settle_max_q), wb.wbs_dat_i, wb.wbs_sel_i));
      end
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;

  // Effective limits: a zero PORST_LEN still gives one cycle, a zero
  // SETTLE_MAX means the largest count.
  assign len_eff_s  = (porst_len_act_q == {CNT_W{1'b0}}) ? CNT_W'(1) : porst_len_act_q;
  assign smax_eff_s = (settle_max_act_q == {CNT_W{1'b0}}) ? {CNT_W{1'b1}} : settle_max_act_q;
  assign cnt_inc_s  = cnt_q + CNT_W'(1);

  // Consecutive-high filter and the two ways out of SETTLE.
  always_comb begin
    filt_d    = {FILT_W{1'b0}};
    ok_hit_s  = 1'b0;
    timeout_s = 1'b0;
    if (ok_s) begin
      filt_d = (filt_q == FILT_TGT) ? filt_q : filt_q + FILT_W'(1);
    end else begin
      filt_d = {FILT_W{1'b0}};
    end
    ok_hit_s  = (filt_d == FILT_TGT);
    timeout_s = (cnt_inc_s >= smax_eff_s);
  end

  assign done_entry_s = (state_q == ST_SETTLE) & ~abort_s & ~start_s & (ok_hit_s | timeout_s);

  // Sequencer FSM with registered porst/ready/fault/capture outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q          <= ST_IDLE;
      porst_q          <= 1'b1;
      ready_q          <= 1'b0;
      fault_q          <= 1'b0;
      cnt_q            <= {CNT_W{1'b0}};
      cap_q            <= {CNT_W{1'b0}};
      filt_q           <= {FILT_W{1'b0}};
      porst_len_act_q  <= CNT_W'(PORST_LEN_RST);
      settle_max_act_q <= CNT_W'(SETTLE_MAX_RST);
    end else if (abort_s) begin
      // ABORT wins over a START carried in the same write.
      state_q <= ST_IDLE;
      porst_q <= 1'b1;
      ready_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      filt_q  <= {FILT_W{1'b0}};
    end else if (start_s) begin
      // cnt_q counts PORST cycles starting with this one.
      state_q          <= ST_PORST;
      porst_q          <= 1'b1;
      ready_q          <= 1'b0;
      fault_q          <= 1'b0;
      cnt_q            <= CNT_W'(1);
      cap_q            <= {CNT_W{1'b0}};
      filt_q           <= {FILT_W{1'b0}};
      porst_len_act_q  <= porst_len_q;
      settle_max_act_q <= settle_max_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          porst_q <= 1'b1;
        end
        ST_PORST: begin
          if (cnt_q >= len_eff_s) begin
            state_q <= ST_SETTLE;
            porst_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        ST_SETTLE: begin
          cnt_q  <= cnt_inc_s;
          filt_q <= filt_d;
          if (ok_hit_s) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            cap_q   <= cnt_inc_s;
          end else if (timeout_s) begin
            state_q <= ST_DONE;
            fault_q <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // Loss of the in-range flag after settling is a fault.
          if (ready_q && !ok_s) begin
            ready_q <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            ready_q <= ready_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          porst_q <= 1'b1;
        end
      endcase
    end
  end

  assign porst_o     = porst_q;
  assign bgr_ready_o = ready_q;

`ifdef BGR_CTRL_IRQ_EN
  logic irq_q;

  // Done interrupt; a set on the same edge as a clear wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_q <= 1'b0;
    end else if (done_entry_s) begin
      irq_q <= 1'b1;
    end else if (irq_clr_s) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_q;
    end
  end

  assign irq_o = irq_q;

  logic unused_s;
  assign unused_s = ^wb.wbs_adr_i[1:0];
`else
  assign irq_o = 1'b0;

  logic unused_s;
  assign unused_s = ^{wb.wbs_adr_i[1:0], done_entry_s, irq_clr_s};
`endif

endmodule

// File: tb/tb_bgr_ctrl.sv
// tb_bgr_ctrl: directed/randomized self-checking bench for bgr_ctrl.
module tb_bgr_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          OKF  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vbg = 1'b0;
  logic porst;
  logic rdy;
  logic irq;

  int n_cmp = 0;
  int n_bad = 0;

  bgr_ctrl_if wb();

  bgr_ctrl #(.BASE_ADDR(BASE), .CNT_W(16), .OK_FILT(OKF)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .wb          (wb),
    .vbg_ok_i    (vbg),
    .porst_o     (porst),
    .bgr_ready_o (rdy),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    int k = 0;
    while (wb.wbs_ack_o === 1'b1 && k < 4) begin
      k++;
      @(negedge clk);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_idle();
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_sel_i = s;    wb.wbs_adr_i = a;    wb.wbs_dat_i = d;
    @(negedge clk);
    chk("wr_ack", 32'(wb.wbs_ack_o), 32'd1);
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bus_idle();
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = a;
    @(negedge clk);
    chk("rd_ack", 32'(wb.wbs_ack_o), 32'd1);
    d = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
  endtask

  // Counts sampled cycles with porst_o high, bounded.
  task automatic porst_width(output int n);
    n = 0;
    while (porst === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Reference model pieces.
  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return 16'(({16'd0, old_v} & ~m) | (new_v & m));
  endfunction

  function automatic logic [31:0] status(input int st, input bit r, input bit f, input int cap);
    return (32'(cap) << 16) | (32'(f) << 3) | (32'(r) << 2) | 32'(st);
  endfunction

  initial begin
    logic [31:0] rd;
    logic [15:0] m_len;
    int len, d, smax, n, cap;

    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    chk("rst_porst", 32'(porst), 32'd1);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(BASE + 32'hC, rd); chk("status_rst", rd, 32'd0);
    wb_read(BASE + 32'h4, rd); chk("len_rst", rd, 32'h64);
    wb_read(BASE + 32'h8, rd); chk("smax_rst", rd, 32'hFFFF);
    chk("porst_idle", 32'(porst), 32'd1);
    m_len = 16'd100;

    // Outside the window: acked, ignored, reads 0
    wb_write(BASE + 32'h14, 32'd7, 4'hF);
    wb_read(BASE + 32'h14, rd); chk("miss_rd", rd, 32'd0);
    wb_read(BASE + 32'h4, rd);  chk("miss_wr", rd, 32'(m_len));

    // Byte lanes
    wb_write(BASE + 32'h4, 32'h0000_1234, 4'b0001); m_len = merge(m_len, 32'h0000_1234, 4'b0001);
    wb_read(BASE + 32'h4, rd); chk("sel0", rd, 32'(m_len));
    wb_write(BASE + 32'h4, 32'h0000_AB00, 4'b0010); m_len = merge(m_len, 32'h0000_AB00, 4'b0010);
    wb_read(BASE + 32'h4, rd); chk("sel1", rd, 32'(m_len));

    // Normal power-up with random PORST_LEN and ok delay
    len = $urandom_range(1, 12);
    d   = $urandom_range(5, 30);
    wb_write(BASE + 32'h4, 32'(len), 4'hF);
    wb_write(BASE + 32'h0, 32'h1, 4'hF);
    porst_width(n);
    chk("porst_len", 32'(n), 32'(len));
    repeat (d) @(negedge clk);
    vbg = 1'b1;
    repeat (5) @(negedge clk);
    chk("ready_early", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("ready_set", 32'(rdy), 32'd1);
    cap = d + 2 + OKF;
    wb_read(BASE + 32'hC, rd); chk("status_ready", rd, status(3, 1'b1, 1'b0, cap));
    chk("porst_done", 32'(porst), 32'd0);

    // Loss of ok after ready
    vbg = 1'b0;
    repeat (3) @(negedge clk);
    vbg = 1'b1;
    repeat (4) @(negedge clk);
    chk("drop_ready", 32'(rdy), 32'd0);
    chk("drop_porst", 32'(porst), 32'd0);
    wb_read(BASE + 32'hC, rd); chk("status_drop", rd, status(3, 1'b0, 1'b1, cap));

    // Settle timeout
    smax = $urandom_range(20, 60);
    wb_write(BASE + 32'h8, 32'(smax), 4'hF);
    vbg = 1'b0;
    wb_write(BASE + 32'h0, 32'h1, 4'hF);
    porst_width(n);
    chk("porst_len2", 32'(n), 32'(len));
    repeat (smax - 1) @(negedge clk);
    wb_read(BASE + 32'hC, rd); chk("to_before", rd, status(2, 1'b0, 1'b0, 0));
    wb_read(BASE + 32'hC, rd); chk("to_fault", rd, status(3, 1'b0, 1'b1, 0));
    chk("to_ready", 32'(rdy), 32'd0);
`ifdef BGR_CTRL_IRQ_EN
    chk("irq_set", 32'(irq), 32'd1);
    wb_write(BASE + 32'hC, 32'h10, 4'h1);
    chk("irq_clr", 32'(irq), 32'd0);
`else
    wb_write(BASE + 32'hC, 32'h10, 4'h1);
    chk("irq_off", 32'(irq), 32'd0);
`endif

    // Zero PORST_LEN/SETTLE_MAX, then ABORT+START during SETTLE
    wb_write(BASE + 32'h4, 32'd0, 4'hF);
    wb_write(BASE + 32'h8, 32'd0, 4'hF);
    wb_write(BASE + 32'h0, 32'h1, 4'hF);
    porst_width(n);
    chk("porst_min", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    wb_write(BASE + 32'h0, 32'h3, 4'hF);
    wb_read(BASE + 32'hC, rd); chk("abort_idle", rd, 32'd0);
    chk("abort_porst", 32'(porst), 32'd1);
    vbg = 1'b1;
    repeat (30) @(negedge clk);
    wb_read(BASE + 32'hC, rd); chk("abort_stay", rd, 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd0);

    // Short ok glitches never satisfy the filter
    vbg = 1'b0;
    wb_write(BASE + 32'h0, 32'h1, 4'hF);
    porst_width(n);
    for (int g = 0; g < 6; g++) begin
      vbg = 1'b1;
      repeat (OKF - 1) @(negedge clk);
      vbg = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    wb_read(BASE + 32'hC, rd); chk("glitch_st", rd, status(2, 1'b0, 1'b0, 0));
    chk("glitch_rdy", 32'(rdy), 32'd0);

    // Continuous strobe: ack every other cycle
    bus_idle();
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = BASE + 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ack_pat", 32'(wb.wbs_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("ack_dat", wb.wbs_dat_o, 32'd0);
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;

    // Reset in the middle of a transfer
    bus_idle();
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_adr_i = BASE + 32'hC;
    @(negedge clk);
    chk("mid_ack", 32'(wb.wbs_ack_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_drop", 32'(wb.wbs_ack_o), 32'd0);
    chk("mid_porst", 32'(porst), 32'd1);
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(BASE + 32'h4, rd); chk("len_rst2", rd, 32'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bgr_ctrl.md
BGR_CTRL -- requirements
Module: bgr_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the 16-byte register window.
REQ-002 SHALL have parameter CNT_W, default 16, width of the pulse, settle and timeout counters.
REQ-003 SHALL have parameter OK_FILT, default 4, number of consecutive synchronized vbg_ok_i highs required to declare settled.
REQ-004 SHALL have port: wb_clk_i  in  1  single clock.
REQ-005 SHALL have port: wb_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe and write.
REQ-007 SHALL have port: wbs_sel_i  in  4  byte lanes.
REQ-008 SHALL have port: wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
REQ-009 SHALL have port: wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-010 SHALL have port: vbg_ok_i  in  1  asynchronous bandgap-in-range comparator flag.
REQ-011 SHALL have port: porst_o  out  1  power-on reset to the bandgap macro, active-high.
REQ-012 SHALL have port: bgr_ready_o  out  1  reference settled; irq_o  out  1  interrupt.

Function
REQ-013 SHALL decode wbs_adr_i[31:4]==BASE_ADDR[31:4] with word select adr[3:2]; non-matching accesses are acked, write nothing and read 0.
REQ-014 SHALL map: 0x0 CTRL (W: bit0 START, bit1 ABORT, self-clearing, read 0); 0x4 PORST_LEN[CNT_W-1:0]; 0x8 SETTLE_MAX[CNT_W-1:0]; 0xC STATUS (R: [1:0] state, bit2 ready, bit3 fault, [31:16] captured settle count; W: bit4 irq clear).
REQ-015 SHALL honour wbs_sel_i per byte on PORST_LEN and SETTLE_MAX; CTRL and STATUS act when sel[0] is set.
REQ-016 SHALL assert wbs_ack_o exactly one cycle after cyc&stb is seen with ack low (ack <= cyc&stb&!ack), registering wbs_dat_o in the same edge; back-to-back strobes ack every other cycle.
REQ-017 SHALL synchronize vbg_ok_i through two flops before any use.
REQ-018 SHALL implement FSM IDLE(0), PORST(1), SETTLE(2), DONE(3); DONE with fault=1 denotes failure.
REQ-019 IDLE: porst_o=1; START -> PORST, clearing ready, fault and the counters.
REQ-020 PORST: porst_o=1 for max(PORST_LEN,1) cycles, then -> SETTLE.
REQ-021 SETTLE: porst_o=0, counter increments each cycle; OK_FILT consecutive synced highs -> DONE with ready=1 and count captured; counter reaching SETTLE_MAX (0 treated as 2^CNT_W-1) first -> DONE with fault=1.
REQ-022 DONE/ready: synced vbg_ok low for one cycle SHALL clear ready and set fault; porst_o stays 0.
REQ-023 START in PORST or SETTLE SHALL restart PORST; ABORT in any state -> IDLE, with ABORT winning over simultaneous START.
REQ-024 bgr_ready_o SHALL equal STATUS.ready, registered.
REQ-025 Register writes landing during PORST/SETTLE SHALL take effect only at the next START.

Reset
REQ-026 On wb_rst_n low: state IDLE, porst_o=1, bgr_ready_o=0, irq_o=0, wbs_ack_o=0, wbs_dat_o=0, PORST_LEN=16'd100, SETTLE_MAX=16'hFFFF, counters and synchronizer 0; reset mid-transfer drops the ack.

Configuration
REQ-027 With BGR_CTRL_IRQ_EN defined, irq_o SHALL set on entry to DONE and clear on STATUS bit4 write, with set winning a simultaneous clear; when undefined, irq_o SHALL be tied 0 and STATUS bit4 ignored, with the port retained.

Structure
REQ-028 A shared package bgr_pkg SHALL hold the FSM state enum, register offsets, STATUS bit positions and reset defaults.
REQ-029 The two-flop synchronizer SHALL be a sub-module bgr_sync2; all other logic stays in bgr_ctrl.

Verification
REQ-030 Reset, then read STATUS -> 0x0000_0000, porst_o=1; read 0x4 -> 0x64.
REQ-031 PORST_LEN=5, START, vbg_ok_i rises 20 cycles after porst_o falls -> porst_o high exactly 5 cycles, STATUS.state=3, ready=1, count about 20+2+OK_FILT, bgr_ready_o=1.
REQ-032 SETTLE_MAX=50, vbg_ok_i held 0, START -> fault=1 after 50 SETTLE cycles, ready=0, irq_o=1 (IRQ_EN), cleared by a STATUS bit4 write.
REQ-033 Ready, then vbg_ok_i drops for 3 cycles -> ready=0, fault=1, porst_o stays 0.
REQ-034 Write CTRL=0x3 during SETTLE -> state IDLE, porst_o=1, no DONE.
REQ-035 vbg_ok_i glitching high for 3 cycles at a time (OK_FILT=4) -> no ready; continuous strobes -> ack pattern 1,0,1,0.
